// File: rtl/coin_acceptor.sv
// coin_acceptor: coin-slot sensor -> 2-flop sync -> debounce -> width measure -> coin code.
// Latency: coin/reject pulse DEB_CYCLES+3 edges after coin_sense is first sampled low.
// No backpressure. `define COIN_ACCEPTOR_TALLY_EN adds the saturating coin_total counter.
module coin_acceptor #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned NICKEL_MIN = 8,
   parameter int unsigned NICKEL_MAX = 15,
   parameter int unsigned DIME_MIN   = 16,
   parameter int unsigned DIME_MAX   = 31,
   parameter int unsigned JAM_CYCLES = 64,
   parameter int unsigned CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_sense,
   input  logic       jam_clr,
   output logic [1:0] coin,
   output logic       reject,
`ifdef COIN_ACCEPTOR_TALLY_EN
   output logic       jam,
   output logic [7:0] coin_total
`else
   output logic       jam
`endif
);
   localparam int unsigned DW = $clog2(DEB_CYCLES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_MEASURE, ST_JAM} state_t;

   logic             s1, s2, deb;
   logic [DW-1:0]    deb_cnt;
   state_t           state, state_nxt;
   logic [CNT_W-1:0] width, width_nxt;
   logic [1:0]       coin_nxt;
   logic             reject_nxt, jam_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= coin_sense;
         s2 <= s1;
      end
   end

   // Rising and falling paths share this counter, so measured width equals raw high time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb     <= 1'b0;
         deb_cnt <= '0;
      end else if (s2 == deb) begin
         deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
         deb     <= ~deb;
         deb_cnt <= '0;
      end else begin
         deb_cnt <= deb_cnt + DW'(1);
      end
   end

   always_comb begin
      state_nxt  = state;
      width_nxt  = width;
      coin_nxt   = 2'b00;
      reject_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (deb) begin
               state_nxt = ST_MEASURE;
               width_nxt = CNT_W'(1);
            end
         end
         ST_MEASURE: begin
            if (!deb) begin
               state_nxt = ST_IDLE;
               if (width >= CNT_W'(NICKEL_MIN) && width <= CNT_W'(NICKEL_MAX))
                  coin_nxt = 2'b01;
               else if (width >= CNT_W'(DIME_MIN) && width <= CNT_W'(DIME_MAX))
                  coin_nxt = 2'b10;
               else
                  reject_nxt = 1'b1;
            end else begin
               width_nxt = width + CNT_W'(1);
               if (width == CNT_W'(JAM_CYCLES - 1))
                  state_nxt = ST_JAM;
            end
         end
         ST_JAM: begin
            if (jam_clr && !deb)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      jam_nxt = (state_nxt == ST_JAM);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         width  <= '0;
         coin   <= 2'b00;
         reject <= 1'b0;
         jam    <= 1'b0;
      end else begin
         state  <= state_nxt;
         width  <= width_nxt;
         coin   <= coin_nxt;
         reject <= reject_nxt;
         jam    <= jam_nxt;
      end
   end

`ifdef COIN_ACCEPTOR_TALLY_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         coin_total <= 8'd0;
      else if (coin != 2'b00 && coin_total != 8'hFF)
         coin_total <= coin_total + 8'd1;
   end
`endif

endmodule
